// File: rtl/mux_pkg.sv
// Shared types for the two-input stream arbiter: select encoding (matches mux2to1)
// and output-register occupancy.
package mux_pkg;

    typedef enum logic {SEL_A = 1'b0, SEL_B = 1'b1} mux_sel_e;

    typedef enum logic {OCC_EMPTY = 1'b0, OCC_FULL = 1'b1} occ_e;

    localparam int MUX_DATA_WITH_DEFAULT = 8;

endpackage

// File: rtl/rr_pick2.sv
// Combinational two-way round-robin pick: a lone requester wins outright,
// and under contention the source that did not win last time wins.
module rr_pick2
    import mux_pkg::*;
(
    input  logic     valid_a_i,
    input  logic     valid_b_i,
    input  mux_sel_e last_i,
    output mux_sel_e grant_o,
    output logic     grant_valid_o
);

    always_comb begin
        grant_o       = SEL_A;
        grant_valid_o = valid_a_i || valid_b_i;
        if (valid_a_i && valid_b_i) begin
            grant_o = (last_i == SEL_A) ? SEL_B : SEL_A;
        end else if (valid_b_i) begin
            grant_o = SEL_B;
        end
    end

endmodule

// File: rtl/mux_stream_arb2.sv
// Two-input round-robin stream arbiter feeding a one-entry output register;
// o_sel is meant to drive the select of a downstream mux2to1.
module mux_stream_arb2
    import mux_pkg::*;
#(
    parameter int DATA_WITH = MUX_DATA_WITH_DEFAULT
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic [DATA_WITH-1:0] i_a,
    input  logic                 i_a_valid,
    output logic                 o_a_ready,
    input  logic [DATA_WITH-1:0] i_b,
    input  logic                 i_b_valid,
    output logic                 o_b_ready,
    output logic [DATA_WITH-1:0] o_y,
    output logic                 o_sel,
    output logic                 o_valid,
    input  logic                 i_ready
);

    occ_e                 occ_q, occ_d;
    mux_sel_e             sel_q, sel_d;
    mux_sel_e             last_q, last_d;
    logic [DATA_WITH-1:0] y_q, y_d;

    mux_sel_e grant;
    logic     grant_valid;
    logic     load_en;
    logic     in_xfer;

    rr_pick2 u_pick (
        .valid_a_i     (i_a_valid),
        .valid_b_i     (i_b_valid),
        .last_i        (last_q),
        .grant_o       (grant),
        .grant_valid_o (grant_valid)
    );

    // The register can take a new word when empty or when its word leaves this cycle.
    assign load_en   = (occ_q == OCC_EMPTY) || i_ready;
    assign in_xfer   = grant_valid && load_en && !i_rst;
    assign o_a_ready = in_xfer && (grant == SEL_A);
    assign o_b_ready = in_xfer && (grant == SEL_B);

    always_comb begin
        occ_d  = occ_q;
        sel_d  = sel_q;
        last_d = last_q;
        y_d    = y_q;
        if (in_xfer) begin
            occ_d  = OCC_FULL;
            sel_d  = grant;
            last_d = grant;
            y_d    = (grant == SEL_B) ? i_b : i_a;
        end else if (i_ready) begin
            occ_d  = OCC_EMPTY;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            occ_q  <= OCC_EMPTY;
            sel_q  <= SEL_A;
            last_q <= SEL_B;
            y_q    <= '0;
        end else begin
            occ_q  <= occ_d;
            sel_q  <= sel_d;
            last_q <= last_d;
            y_q    <= y_d;
        end
    end

    assign o_valid = (occ_q == OCC_FULL);
    assign o_sel   = sel_q;
    assign o_y     = y_q;

endmodule
